instr_fetch_stage: RTL and testbench

- Fetch stage directly upstream of read_ROM.
- Drives the 13-bit ROM address and tracks in-flight reads across the ROM's fixed read latency.
- Captures each returned 16-bit word into a small show-ahead buffer and presents it with its PC to decode over a valid/ready handshake.
- Supports stall via backpressure and PC redirect with flush.

---
 rtl/instr_fetch_stage.sv | 78 +++++++
 tb/tb_instr_fetch_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: drives ROM addresses, tracks reads across the ROM latency with a tag pipe,
// and buffers returned words in a show-ahead queue handed to decode over valid/ready.
module instr_fetch_stage #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1,
  parameter int BUF_DEPTH   = ROM_LATENCY + 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [1:0]        inflight
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [ADDR_W-1:0]      pc;
  logic [ROM_LATENCY-1:0] tv;
  logic [ADDR_W-1:0]      tag [ROM_LATENCY];
  logic [DATA_W-1:0]      bdata [BUF_DEPTH];
  logic [ADDR_W-1:0]      bpc [BUF_DEPTH];
  logic [PW-1:0]          rd, wr;
  logic [CW-1:0]          count;
  logic                   issue, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + {1'b0, tv[i]};
  end
  // Credits use pre-pop occupancy so the issue decision never depends on instr_ready.
  assign issue       = enable && !redirect_valid && (int'(count) + int'(inflight)) < BUF_DEPTH;
  assign push        = tv[ROM_LATENCY-1];
  assign instr_valid = count != '0;
  assign pop         = instr_valid && instr_ready;
  assign rom_address = pc;
  assign instr_data  = instr_valid ? bdata[rd] : '0;
  assign instr_pc    = instr_valid ? bpc[rd] : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= '0;
      tv    <= '0;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_addr;
      tv    <= '0;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (issue) pc <= pc + 1'b1;
      tv <= (tv << 1) | ROM_LATENCY'(issue);
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    tag[0] <= pc;
    for (int i = 1; i < ROM_LATENCY; i++) tag[i] <= tag[i-1];
    if (push && !redirect_valid) begin
      bdata[wr] <= rom_data;
      bpc[wr]   <= tag[ROM_LATENCY-1];
    end
  end
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !redirect_valid && count == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed checks of streaming, stall, redirect, wrap, enable drop and async reset.
module tb_instr_fetch_stage;
  logic        clock = 1'b0;
  logic        reset_n, enable, redirect_valid, instr_ready, instr_valid;
  logic [12:0] redirect_addr, rom_address, instr_pc, rom_q;
  logic [15:0] rom_data, instr_data;
  logic [1:0]  inflight;
  int          total = 0, bad = 0;
  instr_fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .rom_address(rom_address), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .inflight(inflight)
  );
  always #5 clock = ~clock;
  always @(posedge clock) rom_q <= rom_address;
  assign rom_data = {3'b000, rom_q};
  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset_n = 0; enable = 0; redirect_valid = 0; redirect_addr = '0; instr_ready = 0;
    tick;
    chk("rst_valid", instr_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_data", instr_data, 0);
    reset_n = 1; enable = 1; instr_ready = 1;
    tick;
    chk("e1_valid", instr_valid, 0);
    chk("e1_inflight", inflight, 1);
    chk("e1_addr", rom_address, 1);
    for (int k = 2; k <= 7; k++) begin
      tick;
      chk("run_valid", instr_valid, 1);
      chk("run_pc", instr_pc, k - 2);
      chk("run_data", instr_data, k - 2);
    end
    instr_ready = 0;
    for (int j = 0; j < 10; j++) begin
      tick;
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", instr_pc, 5);
      chk("stall_data", instr_data, 5);
    end
    chk("stall_inflight", inflight, 0);
    chk("stall_addr", rom_address, 8);
    instr_ready = 1;
    for (int j = 1; j <= 5; j++) begin
      tick;
      chk("resume_valid", instr_valid, 1);
      chk("resume_pc", instr_pc, 5 + j);
      chk("resume_data", instr_data, 5 + j);
    end
    instr_ready = 0;
    tick;
    chk("prered_inflight", inflight, 1);
    chk("prered_pc", instr_pc, 10);
    redirect_valid = 1; redirect_addr = 13'h0100; instr_ready = 1;
    tick;
    redirect_valid = 0;
    chk("red_valid", instr_valid, 0);
    chk("red_inflight", inflight, 0);
    chk("red_addr", rom_address, 13'h0100);
    tick;
    chk("red1_valid", instr_valid, 0);
    chk("red1_inflight", inflight, 1);
    tick;
    chk("red2_valid", instr_valid, 1);
    chk("red2_pc", instr_pc, 13'h0100);
    chk("red2_data", instr_data, 16'h0100);
    tick;
    chk("red3_pc", instr_pc, 13'h0101);
    chk("red3_data", instr_data, 16'h0101);
    redirect_valid = 1; redirect_addr = 13'd8190;
    tick;
    redirect_valid = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("wrap_valid", instr_valid, 1);
      chk("wrap_pc", instr_pc, (8190 + i) % 8192);
      chk("wrap_data", instr_data, (8190 + i) % 8192);
    end
    chk("wrap_addr", rom_address, 3);
    enable = 0;
    tick;
    chk("en_valid", instr_valid, 1);
    chk("en_pc", instr_pc, 2);
    chk("en_inflight", inflight, 0);
    chk("en_addr", rom_address, 3);
    tick;
    chk("en_drain", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("en_idle_valid", instr_valid, 0);
      chk("en_idle_addr", rom_address, 3);
      chk("en_idle_inflight", inflight, 0);
    end
    enable = 1;
    repeat (4) tick;
    chk("burst_valid", instr_valid, 1);
    chk("burst_inflight", inflight, 1);
    #3 reset_n = 0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_addr", rom_address, 0);
    chk("arst_pc", instr_pc, 0);
    reset_n = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
